// File: rtl/crp16_alu_serial_addsub.sv
// CRP16 digit-serial add/sub unit: CHUNK bits per cycle over a WIDTH-bit word.
// Handles ADD/SUB/ADC/SBC with carry, overflow, zero and negative flags.
module crp16_alu_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             c_out,
    output logic             v,
    output logic             z,
    output logic             n
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = CHUNK + 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             c_out_q, c_out_d;
    logic             v_q, v_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             done_q, done_d;

    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] res;
    logic             last;
    logic             take;

    always_comb begin
        sum = {1'b0, x_q[int'(k_q)*CHUNK +: CHUNK]}
            + {1'b0, y_q[int'(k_q)*CHUNK +: CHUNK]}
            + CW'(cy_q);
        res = acc_q;
        res[int'(k_q)*CHUNK +: CHUNK] = sum[CHUNK-1:0];
        last = (k_q == K_LAST);
        // The final-chunk edge may accept a new op, so held start runs every N cycles
        take = start && ((state_q == IDLE) || last);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        cy_d    = cy_q;
        r_d     = r_q;
        c_out_d = c_out_q;
        v_d     = v_q;
        z_d     = z_q;
        n_d     = n_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
            end
            RUN: begin
                acc_d = res;
                cy_d  = sum[CHUNK];
                k_d   = k_q + KW'(1);
                if (last) begin
                    state_d = IDLE;
                    k_d     = '0;
                    done_d  = 1'b1;
                    r_d     = res;
                    c_out_d = sum[CHUNK];
                    v_d     = (x_q[WIDTH-1] == y_q[WIDTH-1])
                           && (res[WIDTH-1] != x_q[WIDTH-1]);
                    z_d     = (res == '0);
                    n_d     = res[WIDTH-1];
                end
            end
        endcase

        if (take) begin
            state_d = RUN;
            k_d     = '0;
            x_d     = x;
            y_d     = op[0] ? ~y : y;
            cy_d    = op[1] ? c_in : op[0];
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            cy_q    <= 1'b0;
            r_q     <= '0;
            c_out_q <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            cy_q    <= cy_d;
            r_q     <= r_d;
            c_out_q <= c_out_d;
            v_q     <= v_d;
            z_q     <= z_d;
            n_q     <= n_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign r     = r_q;
    assign c_out = c_out_q;
    assign v     = v_q;
    assign z     = z_q;
    assign n     = n_q;

endmodule

// File: tb/tb_crp16_alu_serial_addsub.sv
// Scoreboard bench for crp16_alu_serial_addsub across four WIDTH/CHUNK configs.
// Expected results come from plain-arithmetic reference model or fixed constants.
module tb_crp16_alu_serial_addsub;

    localparam int WS[4] = '{16, 16, 16, 32};
    localparam int CS[4] = '{4, 16, 1, 8};
    localparam int NS[4] = '{4, 1, 16, 4};

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [3:0]       start_a = '0;
    logic [3:0][1:0]  op_a = '0;
    logic [3:0][31:0] x_a = '0;
    logic [3:0][31:0] y_a = '0;
    logic [3:0]       cin_a = '0;
    logic [3:0]       busy_a;
    logic [3:0]       done_a;
    logic [3:0][31:0] r_a;
    logic [3:0]       co_a;
    logic [3:0]       v_a;
    logic [3:0]       z_a;
    logic [3:0]       n_a;

    exp_t q[4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = WS[g];
        localparam int C = CS[g];
        logic [W-1:0] r_w;
        crp16_alu_serial_addsub #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk   (clk),
            .reset (reset),
            .start (start_a[g]),
            .op    (op_a[g]),
            .x     (x_a[g][W-1:0]),
            .y     (y_a[g][W-1:0]),
            .c_in  (cin_a[g]),
            .busy  (busy_a[g]),
            .done  (done_a[g]),
            .r     (r_w),
            .c_out (co_a[g]),
            .v     (v_a[g]),
            .z     (z_a[g]),
            .n     (n_a[g])
        );
        assign r_a[g] = 32'(r_w);
    end

    function automatic logic [31:0] wmask(input int w);
        return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Reference: x + (y or ~y) + c0 evaluated in 64-bit arithmetic
    function automatic exp_t model(input int w, input logic [1:0] o,
                                   input logic [31:0] xv, input logic [31:0] yv,
                                   input logic ci);
        exp_t e;
        longint unsigned m, xs, ys, c0, s;
        m  = longint'(wmask(w));
        xs = longint'(xv) & m;
        ys = (o[0] ? ~longint'(yv) : longint'(yv)) & m;
        c0 = o[1] ? longint'(ci) : longint'(o[0]);
        s  = xs + ys + c0;
        e.r = 32'(s & m);
        e.c = ((s >> w) & 1) != 0;
        e.n = ((s >> (w - 1)) & 1) != 0;
        e.z = (s & m) == 0;
        e.v = (((xs >> (w - 1)) & 1) == ((ys >> (w - 1)) & 1))
           && ((((xs >> (w - 1)) & 1) != 0) != e.n);
        e.due = 0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] rv, input logic c,
                                input logic vv, input logic zv, input logic nv);
        exp_t e;
        e.r = rv; e.c = c; e.v = vv; e.z = zv; e.n = nv; e.due = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        for (int g = 0; g < 4; g++) begin
            if (done_a[g] === 1'b1) begin
                n_checks++;
                if (q[g].size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done dut%0d: got done at cycle %0d required none",
                             g, cyc);
                end else begin
                    e = q[g].pop_front();
                    if ({r_a[g], co_a[g], v_a[g], z_a[g], n_a[g]}
                        !== {e.r, e.c, e.v, e.z, e.n}) begin
                        n_fail++;
                        $display("FAIL result dut%0d: got r=%0h c=%b v=%b z=%b n=%b required r=%0h c=%b v=%b z=%b n=%b",
                                 g, r_a[g], co_a[g], v_a[g], z_a[g], n_a[g],
                                 e.r, e.c, e.v, e.z, e.n);
                    end
                    n_checks++;
                    if (cyc != e.due) begin
                        n_fail++;
                        $display("FAIL done_time dut%0d: got cycle %0d required %0d",
                                 g, cyc, e.due);
                    end
                end
            end
        end
    end

    task automatic drain(input int g);
        int t;
        t = 0;
        while (q[g].size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (q[g].size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout dut%0d: got %0d pending required 0",
                     g, q[g].size());
            q[g].delete();
        end
    endtask

    task automatic run_op(input int g, input logic [1:0] o,
                          input logic [31:0] xv, input logic [31:0] yv,
                          input logic ci, input exp_t e);
        exp_t t;
        t = e;
        @(negedge clk);
        op_a[g] = o; x_a[g] = xv; y_a[g] = yv; cin_a[g] = ci;
        start_a[g] = 1'b1;
        t.due = cyc + 1 + NS[g];
        q[g].push_back(t);
        @(negedge clk);
        start_a[g] = 1'b0;
        x_a[g] = $urandom; y_a[g] = $urandom; op_a[g] = 2'($urandom);
        chk($sformatf("busy_after_start dut%0d", g), 64'(busy_a[g]), 64'd1);
        drain(g);
    endtask

    function automatic logic [31:0] pick(input int w, input int rep);
        logic [31:0] m;
        m = wmask(w);
        case (rep % 10)
            0: return 32'd0;
            1: return m;
            2: return 32'd1 << (w - 1);
            3: return (32'd1 << (w - 1)) - 32'd1;
            default: return $urandom & m;
        endcase
    endfunction

    initial begin
        exp_t lo, hi;
        int acc;
        logic [31:0] xv, yv;
        logic ci;

        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++)
            chk($sformatf("reset_state dut%0d", g),
                64'({busy_a[g], done_a[g], r_a[g], co_a[g], v_a[g], z_a[g], n_a[g]}),
                64'd0);
        reset = 1'b0;

        run_op(0, 2'b00, 32'h7FFF, 32'h0001, 1'b0, mk(32'h8000, 0, 1, 0, 1));
        run_op(0, 2'b01, 32'h0000, 32'h0001, 1'b0, mk(32'hFFFF, 0, 0, 0, 1));
        run_op(0, 2'b01, 32'h1234, 32'h1234, 1'b1, mk(32'h0000, 1, 0, 1, 0));
        run_op(0, 2'b10, 32'hFFFF, 32'h0000, 1'b1, mk(32'h0000, 1, 0, 1, 0));
        run_op(0, 2'b11, 32'h8000, 32'h0001, 1'b1, mk(32'h7FFF, 1, 1, 0, 0));
        run_op(0, 2'b11, 32'h8000, 32'h0001, 1'b0, mk(32'h7FFE, 1, 1, 0, 0));
        run_op(0, 2'b00, 32'h1234, 32'h0000, 1'b1, mk(32'h1234, 0, 0, 0, 0));

        // 32-bit add split over two 16-bit words
        lo = model(16, 2'b00, 32'h0001, 32'hFFFF, 1'b0);
        chk("chain_lo_model", {31'd0, lo.r, lo.c}, {31'd0, 32'h0000, 1'b1});
        run_op(0, 2'b00, 32'h0001, 32'hFFFF, 1'b0, lo);
        hi = model(16, 2'b10, 32'h0000, 32'h0000, lo.c);
        run_op(0, 2'b10, 32'h0000, 32'h0000, lo.c, mk(32'h0001, 0, 0, 0, 0));
        chk("chain_hi_model", 64'(hi.r), 64'h0001);

        // start pulsed mid-operation must be ignored
        @(negedge clk);
        op_a[0] = 2'b00; x_a[0] = 32'h0100; y_a[0] = 32'h0023; start_a[0] = 1'b1;
        acc = cyc + 1;
        q[0].push_back('{r: 32'h0123, c: 0, v: 0, z: 0, n: 0, due: acc + 4});
        @(negedge clk);
        start_a[0] = 1'b0;
        @(negedge clk);
        op_a[0] = 2'b01; x_a[0] = 32'hAAAA; y_a[0] = 32'h5555; start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        drain(0);
        repeat (8) @(negedge clk);

        // start held high: one result every N cycles
        @(negedge clk);
        op_a[0] = 2'b00; x_a[0] = 32'h0011; y_a[0] = 32'h0022; start_a[0] = 1'b1;
        acc = cyc + 1;
        q[0].push_back('{r: 32'h0033, c: 0, v: 0, z: 0, n: 0, due: acc + 4});
        for (int j = 0; j < 3; j++) begin
            while (cyc != acc) @(negedge clk);
            xv = $urandom & 32'hFFFF; yv = $urandom & 32'hFFFF;
            op_a[0] = 2'(j); x_a[0] = xv; y_a[0] = yv; cin_a[0] = 1'b1;
            lo = model(16, 2'(j), xv, yv, 1'b1);
            acc = acc + 4;
            lo.due = acc + 4;
            q[0].push_back(lo);
        end
        while (cyc != acc) @(negedge clk);
        start_a[0] = 1'b0;
        drain(0);

        // reset during chunk 2 aborts silently
        run_op(0, 2'b00, 32'h4000, 32'h0001, 1'b0, mk(32'h4001, 0, 0, 0, 0));
        @(negedge clk);
        op_a[0] = 2'b00; x_a[0] = 32'h1111; y_a[0] = 32'h2222; start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_outputs",
            64'({busy_a[0], done_a[0], r_a[0], co_a[0], v_a[0], z_a[0], n_a[0]}),
            64'd0);
        reset = 1'b0;
        repeat (8) @(negedge clk);

        for (int g = 0; g < 4; g++) begin
            for (int o = 0; o < 4; o++) begin
                for (int rep = 0; rep < 250; rep++) begin
                    xv = pick(WS[g], rep);
                    yv = pick(WS[g], rep / 3);
                    ci = 1'($urandom_range(0, 1));
                    run_op(g, 2'(o), xv, yv, ci, model(WS[g], 2'(o), xv, yv, ci));
                end
            end
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

endmodule
